// File: rtl/cfg_pkg.sv
// +--------------------------------------------------------------------+
// | cfg_pkg : shared constants for the configuration bitstream loader   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cfg_pkg;

  typedef logic [1:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE  = 2'd0;
  localparam cfg_state_t ST_SHIFT = 2'd1;
  localparam cfg_state_t ST_FULL  = 2'd2;

  // Fabric-wide defaults for the routing select bus
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SEL_W  = 2;

endpackage

`default_nettype wire

// File: rtl/cfg_shift_reg.sv
// +--------------------------------------------------------------------+
// | cfg_shift_reg : shadow register with saturating write-index counter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cfg_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_wr_en) begin
      // Indices at or beyond WIDTH (e.g. a trailing check bit) are counted but not stored
      for (int i = 0; i < WIDTH; i++) begin
        if (r_count == CNT_W'(i)) begin
          r_data[i] <= i_bit;
        end
      end
      if (r_count != CNT_W'(CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/config_bitstream_loader.sv
// +--------------------------------------------------------------------+
// | config_bitstream_loader : serial config load, atomic commit to the  |
// | select bus. Optional trailing even-parity bit: CFG_PARITY_CHECK_EN  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module config_bitstream_loader
  import cfg_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic                    cfg_data,
  output logic                    cfg_ready,
  input  logic                    commit,
  output logic                    cfg_done,
  output logic                    busy,
  output logic                    err,
  output logic [NUM_CH*SEL_W-1:0] control_signals
);

  localparam int TOTAL_BITS = NUM_CH * SEL_W;
`ifdef CFG_PARITY_CHECK_EN
  localparam int FRAME_BITS = TOTAL_BITS + 1;
`else
  localparam int FRAME_BITS = TOTAL_BITS;
`endif
  localparam int CNT_W = $clog2(TOTAL_BITS + 1);

  cfg_state_t            r_state;
  logic [TOTAL_BITS-1:0] r_ctrl;
  logic [TOTAL_BITS-1:0] w_shadow;
  logic [CNT_W-1:0]      w_count;
  logic                  w_accept;
  logic                  w_last;

  assign w_accept = (r_state == ST_SHIFT) && cfg_valid && !cfg_start;
  assign w_last   = (w_count == CNT_W'(FRAME_BITS - 1));

  cfg_shift_reg #(
    .WIDTH   (TOTAL_BITS),
    .CNT_MAX (TOTAL_BITS),
    .CNT_W   (CNT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_clear (cfg_start),
    .i_wr_en (w_accept),
    .i_bit   (cfg_data),
    .o_data  (w_shadow),
    .o_count (w_count)
  );

`ifdef CFG_PARITY_CHECK_EN
  logic r_err;
  logic w_par_ok;

  // Payload bits are already in the shadow; cfg_data is the parity bit itself
  assign w_par_ok = ~((^w_shadow) ^ cfg_data);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
`ifdef CFG_PARITY_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else if (cfg_start) begin
      r_state <= ST_SHIFT;
`ifdef CFG_PARITY_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_SHIFT: begin
          if (cfg_valid && w_last) begin
`ifdef CFG_PARITY_CHECK_EN
            if (w_par_ok) begin
              r_state <= ST_FULL;
            end else begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
            end
`else
            r_state <= ST_FULL;
`endif
          end
        end
        ST_FULL: begin
          if (commit) begin
            r_ctrl  <= w_shadow;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready       = (r_state == ST_SHIFT);
  assign cfg_done        = (r_state == ST_FULL);
  assign busy            = (r_state != ST_IDLE);
  assign control_signals = r_ctrl;
`ifdef CFG_PARITY_CHECK_EN
  assign err             = r_err;
`else
  assign err             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_config_bitstream_loader.sv
// +--------------------------------------------------------------------+
// | tb_config_bitstream_loader : directed bench with queue-based model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_config_bitstream_loader;

  localparam int NCH = 4;
  localparam int SW  = 2;
  localparam int TB  = NCH * SW;
`ifdef CFG_PARITY_CHECK_EN
  localparam int FLEN = TB + 1;
  localparam int SFLEN = 25;
`else
  localparam int FLEN = TB;
  localparam int SFLEN = 24;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_data = 1'b0;
  logic          commit = 1'b0;
  logic          cfg_ready, cfg_done, busy, err;
  logic [TB-1:0] control_signals;

  logic          s_start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_data = 1'b0;
  logic          s_commit = 1'b0;
  logic          s_ready, s_done, s_busy, s_err;
  logic [23:0]   s_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  config_bitstream_loader #(.NUM_CH(NCH), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .commit(commit),
    .cfg_done(cfg_done), .busy(busy), .err(err),
    .control_signals(control_signals)
  );

  config_bitstream_loader #(.NUM_CH(8), .SEL_W(3)) dut_sweep (
    .clk(clk), .rst(rst), .cfg_start(s_start), .cfg_valid(s_valid),
    .cfg_data(s_data), .cfg_ready(s_ready), .commit(s_commit),
    .cfg_done(s_done), .busy(s_busy), .err(s_err),
    .control_signals(s_ctrl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: received bits kept in a queue, frame packed into the output on commit
  bit            m_q[$];
  bit            m_active = 1'b0;
  bit            m_full = 1'b0;
  bit            m_err = 1'b0;
  logic [TB-1:0] m_ctrl = '0;

  function automatic bit frame_parity_bad();
    bit x = 1'b0;
`ifdef CFG_PARITY_CHECK_EN
    foreach (m_q[i]) x ^= m_q[i];
`endif
    return x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0; m_full = 1'b0; m_err = 1'b0; m_ctrl = '0;
    end else if (cfg_start) begin
      m_q.delete();
      m_active = 1'b1; m_full = 1'b0; m_err = 1'b0;
    end else if (m_active && cfg_valid) begin
      m_q.push_back(cfg_data);
      if (m_q.size() == FLEN) begin
        m_active = 1'b0;
        if (frame_parity_bad()) m_err = 1'b1;
        else m_full = 1'b1;
      end
    end else if (m_full && commit) begin
      for (int i = 0; i < TB; i++) m_ctrl[i] = m_q[i];
      m_full = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready", cfg_ready, m_active);
    chk("done", cfg_done, m_full);
    chk("busy", busy, m_active | m_full);
    chk("err", err, m_err);
    chk("ctrl", control_signals, m_ctrl);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = v[i];
      tick();
      cfg_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input logic [TB-1:0] v, input int gap, input bit bad_par);
    send_bits({24'b0, v}, TB, gap);
`ifdef CFG_PARITY_CHECK_EN
    send_bits({31'b0, (^v) ^ bad_par}, 1, gap);
`else
    if (bad_par) $display("note: parity request ignored in this build");
`endif
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    int exp_ch[4];
    logic [23:0] sframe;
    exp_ch = '{0, 1, 3, 2};
    sframe = 24'hABCDEF;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ctrl", control_signals, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sweep_ctrl", s_ctrl, 0);

    // Basic frame 0xB4
    start_frame();
    send_frame(8'hB4, 0, 1'b0);
    chk("b4_done", cfg_done, 1);
    chk("b4_hold", control_signals, 0);
    do_commit();
    chk("b4_ctrl", control_signals, 8'hB4);
    for (int k = 0; k < 4; k++) chk("b4_chan", control_signals[k*SW +: SW], exp_ch[k]);
    chk("b4_idle", busy, 0);

    // Stalls between bits
    start_frame();
    send_frame(8'h5A, 2, 1'b0);
    chk("5a_done", cfg_done, 1);
    do_commit();
    chk("5a_ctrl", control_signals, 8'h5A);

    // Abort partway, commit during SHIFT ignored
    start_frame();
    send_bits(32'h13, 5, 0);
    do_commit();
    chk("shift_commit_ignored", control_signals, 8'h5A);
    chk("shift_still_ready", cfg_ready, 1);
    start_frame();
    send_frame(8'h0F, 0, 1'b0);
    do_commit();
    chk("abort_ctrl", control_signals, 8'h0F);

    // Start together with commit in FULL: restart wins
    start_frame();
    send_frame(8'hC3, 0, 1'b0);
    cfg_start = 1'b1;
    commit = 1'b1;
    tick();
    cfg_start = 1'b0;
    commit = 1'b0;
    chk("start_commit_ctrl", control_signals, 8'h0F);
    chk("start_commit_ready", cfg_ready, 1);
    send_frame(8'hC3, 0, 1'b0);
    do_commit();
    chk("c3_ctrl", control_signals, 8'hC3);

    // Reset mid-frame
    start_frame();
    send_frame(8'hFF, 0, 1'b0);
    do_commit();
    chk("ff_ctrl", control_signals, 8'hFF);
    start_frame();
    send_bits(32'h5, 3, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", control_signals, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 0);
    chk("arst_done", cfg_done, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", busy, 0);

`ifdef CFG_PARITY_CHECK_EN
    start_frame();
    send_frame(8'hB4, 0, 1'b1);
    chk("par_bad_err", err, 1);
    chk("par_bad_done", cfg_done, 0);
    chk("par_bad_ctrl", control_signals, 0);
    do_commit();
    chk("par_bad_commit", control_signals, 0);
    start_frame();
    chk("par_err_clear", err, 0);
    send_frame(8'hB4, 0, 1'b0);
    chk("par_ok_done", cfg_done, 1);
    do_commit();
    chk("par_ok_ctrl", control_signals, 8'hB4);
`endif

    // 8 channels x 3 bits
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < SFLEN; i++) begin
      s_valid = 1'b1;
      s_data  = (i < 24) ? sframe[i] : ^sframe;
      tick();
    end
    s_valid = 1'b0;
    chk("sweep_done", s_done, 1);
    chk("sweep_hold", s_ctrl, 0);
    s_commit = 1'b1;
    tick();
    s_commit = 1'b0;
    chk("sweep_ctrl", s_ctrl, 24'hABCDEF);
    chk("sweep_ch0", s_ctrl[2:0], 7);
    chk("sweep_ch7", s_ctrl[23:21], 5);
    for (int k = 0; k < 8; k++) chk("sweep_chan", (s_ctrl >> (3*k)) & 24'h7, (sframe >> (3*k)) & 24'h7);
    chk("sweep_idle", s_busy, 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
